sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Arbitrates the single SRAM data port of the unified memory between two bus masters: the core data port (m0) and the DMA/loader port (m1). It grants the port to one master at a time for a burst of 1–16 word accesses with automatic address increment, and returns registered read data. It sits between the core/DMA and the memory's `sram_addr`/`w_sram`/`w_sram_en`/`r_sram` port; the code fetch port is not involved.

## Interface
- `ADDR_W`, 32, address width of master and memory buses.
- `DATA_W`, 32, word width; byte lanes are little-endian, as the memory stores them.
- `LEN_W`, 4, burst length field width; burst = len+1 beats (1..16).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  request; sampled only in IDLE.
- `m0_we`, `m1_we`  in  1  1 = write burst, 0 = read burst; sampled with req.
- `m0_addr`, `m1_addr`  in  ADDR_W  burst start byte address, SRAM-relative; sampled with req.
- `m0_len`, `m1_len`  in  LEN_W  beats minus one; sampled with req.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data for the current beat.
- `m0_gnt`, `m1_gnt`  out  1  high for every beat cycle of the owner's burst (registered).
- `m0_done`, `m1_done`  out  1  one-cycle pulse on the last beat cycle.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, one cycle after each read beat.
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data.
- `mem_addr`  out  ADDR_W  to memory `sram_addr`.
- `mem_wdata`  out  DATA_W  to memory `w_sram`.
- `mem_we`  out  1  to memory `w_sram_en`.
- `mem_rdata`  in  DATA_W  from memory `r_sram` (combinational read).

## Operation
- States: IDLE, BURST.
- IDLE: when any req is high, pick a winner and latch its we, addr and len into the beat address, beat counter and owner registers. Next state is BURST, with the owner's gnt set. With no req, stay in IDLE.
- Arbitration is round-robin: with both reqs high, the master not granted last wins. After reset, last-granted = m1, so m0 wins the first tie.
- BURST, per cycle:
  - `mem_addr` = beat address.
  - `mem_we` = latched we.
  - `mem_wdata` = the owner's wdata (mux by owner).
  - Beat address += 4 (modulo 2^ADDR_W; wraps from 0xFFFFFFFC to 0).
  - Counter decrements.
- Last beat (counter = 0): pulse the owner's done, clear gnt, return to IDLE.
- Read beats: `mem_rdata` is captured into the owner's rdata, with rvalid set on the next cycle. The non-owner's rdata holds its value; its rvalid stays 0.
- Writes commit at the memory on the edge ending the beat cycle. The master must present beat k's data during beat k; updating wdata on the edge after each gnt-high cycle meets this.
- Outside BURST: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- req, addr, len and we changes during BURST are ignored; a burst always completes. Dropping req mid-burst does not abort it.
- Unaligned start addresses are passed through unchanged (the memory supports byte addressing); the increment remains 4.

## Timing
- Reset (rst low, any time, including mid-burst):
  - state = IDLE; all gnt, done and rvalid = 0; rdata = 0; mem_* = 0; counter = 0; last-granted = m1.
  - An in-flight burst is abandoned; writes stop immediately.
- req high in IDLE at cycle 0 → gnt high in cycles 1..1+len. Beat k is at cycle 1+k; done is at cycle 1+len.
- Read beat k → rvalid/rdata at cycle 2+k.
- The arbiter is in IDLE at cycle 2+len. The earliest next grant is at cycle 3+len, giving one dead cycle between bursts.
- No combinational path from req to gnt or mem_*. `mem_wdata` is combinational from the owner's wdata.

## Test plan
- Single read: reset; memory preloaded with 0x0A000008 at SRAM offset 4. m0 reads addr 4, len 0 → m0_gnt at cycle 1, `mem_addr`=4, m0_done at cycle 1, m0_rvalid and m0_rdata=0x0A000008 at cycle 2, back in IDLE at cycle 2.
- Write burst: m1 writes addr 0x10, len 3, with data 0x11111111..0x44444444 presented per beat → `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C; `mem_we` high exactly 4 cycles; a later read burst returns the same 4 words.
- Contention: m0 and m1 both request from reset with len 1 → m0 served first (cycles 1–2), m1 granted at cycle 4. Repeat with both requesting again → m0 after m1 (alternation).
- Address wrap: read addr 0xFFFFFFFC, len 1 → `mem_addr` 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: assert rst at beat 2 of a len-7 write → `mem_we`, gnt and done drop immediately; after release, idle with m0 winning the next tie.
- Ignored mid-burst changes: change m0_addr/len and drop m0_req during a len-3 burst → all 4 beats use the latched values and done fires on beat 4.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin burst arbiter sharing one SRAM data port between core (m0) and DMA (m1)
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                burst, start, pick1, last_beat, rd;
  always_comb begin
    burst     = state_q == BURST;
    start     = !burst && (m0_req || m1_req);
    // on a tie the master not granted last wins
    pick1     = m1_req && (!m0_req || !last_q);
    last_beat = burst && cnt_q == '0;
    rd        = burst && !we_q;
    state_d   = start ? BURST : last_beat ? IDLE : state_q;
    owner_d   = start ? pick1 : owner_q;
    last_d    = start ? pick1 : last_q;
    we_d      = start ? (pick1 ? m1_we : m0_we) : we_q;
    addr_d    = start ? (pick1 ? m1_addr : m0_addr) : burst ? addr_q + ADDR_W'(4) : addr_q;
    cnt_d     = start ? (pick1 ? m1_len : m0_len) : (burst && !last_beat) ? cnt_q - LEN_W'(1) : cnt_q;
    rvalid_d  = {rd && owner_q, rd && !owner_q};
    rdata0_d  = (rd && !owner_q) ? mem_rdata : rdata0_q;
    rdata1_d  = (rd && owner_q) ? mem_rdata : rdata1_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign m0_gnt    = burst && !owner_q;
  assign m1_gnt    = burst && owner_q;
  assign m0_done   = last_beat && !owner_q;
  assign m1_done   = last_beat && owner_q;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_addr  = burst ? addr_q : '0;
  assign mem_we    = burst && we_q;
  assign mem_wdata = burst ? (owner_q ? m1_wdata : m0_wdata) : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized bursts against a cycle-schedule reference model with a decoupled scoreboard
module tb_sram_port_arbiter;
  typedef logic [31:0] dat_t [16];
  typedef struct {int cyc; bit own; logic [31:0] addr; bit we; logic [31:0] wd; bit done;} beat_t;
  typedef struct {int cyc; logic [31:0] d;} rv_t;
  logic clk = 0, rst = 0;
  logic [1:0] req = 0, we_b = 0;
  logic [31:0] addr_v [2];
  logic [31:0] wd [2];
  logic [3:0] len_v [2];
  logic m0_gnt, m1_gnt, m0_done, m1_done, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  int cyc = 0, checks = 0, failures = 0, idle_from = 0;
  bit last = 1;
  logic [31:0] sram [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  beat_t bq [$];
  rv_t rvq [2][$];
  logic [31:0] hold [2];

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m1_req(req[1]), .m0_we(we_b[0]), .m1_we(we_b[1]),
    .m0_addr(addr_v[0]), .m1_addr(addr_v[1]), .m0_len(len_v[0]), .m1_len(len_v[1]),
    .m0_wdata(wd[0]), .m1_wdata(wd[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // memory stand-in: combinational read settled mid-cycle, write committed with the beat
  always @(negedge clk) begin
    mem_rdata = sram.exists(mem_addr) ? sram[mem_addr] : init_word(mem_addr);
    if (mem_we === 1'b1) sram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (rst) begin
    automatic beat_t e = '{default: 0};
    automatic bit eg = bq.size() > 0 && bq[0].cyc == cyc;
    if (eg) e = bq.pop_front();
    chk("gnt", {m1_gnt, m0_gnt}, eg ? (e.own ? 2'b10 : 2'b01) : 2'b00);
    chk("done", {m1_done, m0_done}, (eg && e.done) ? (e.own ? 2'b10 : 2'b01) : 2'b00);
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_we", mem_we, e.we);
    chk("mem_wdata", mem_wdata, e.wd);
    for (int m = 0; m < 2; m++) begin
      automatic bit ev = rvq[m].size() > 0 && rvq[m][0].cyc == cyc;
      automatic rv_t r;
      if (ev) begin r = rvq[m].pop_front(); hold[m] = r.d; end
      chk(m ? "m1_rvalid" : "m0_rvalid", m ? m1_rvalid : m0_rvalid, ev);
      chk(m ? "m1_rdata" : "m0_rdata", m ? m1_rdata : m0_rdata, hold[m]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic dat_t rnd_dat();
    dat_t r;
    foreach (r[k]) r[k] = $urandom;
    return r;
  endfunction

  // schedule: grant one cycle after the arbiter is idle and sees req; beats at consecutive cycles
  task automatic plan(input int m, input bit w, input logic [31:0] a, input int l, input dat_t d,
                      input int c, input int abort, output int g);
    g = (c > idle_from ? c : idle_from) + 1;
    last = m[0];
    idle_from = g + l + 1;
    for (int k = 0; k <= l && k < abort; k++) begin
      automatic logic [31:0] ba = a + 32'(4 * k);
      bq.push_back('{g + k, m[0], ba, w, d[k], k == l});
      if (w) ref_mem[ba] = d[k];
      else rvq[m].push_back('{g + k + 1, ref_mem.exists(ba) ? ref_mem[ba] : init_word(ba)});
    end
  endtask

  task automatic drive(input int m, input bit w, input logic [31:0] a, input int l, input dat_t d,
                       input int g, input bit mess);
    req[m] = 1; we_b[m] = w; addr_v[m] = a; len_v[m] = 4'(l); wd[m] = $urandom;
    while (cyc < g) step();
    for (int k = 0; k <= l; k++) begin
      if (k > 0) step();
      wd[m] = d[k];
      req[m] = (mess && k < l) ? 1'($urandom) : 1'b0;
      if (mess) begin addr_v[m] = $urandom; len_v[m] = 4'($urandom); we_b[m] = 1'($urandom); end
    end
    step();
    wd[m] = $urandom;
    req[m] = 0;
  endtask

  task automatic single(input int m, input bit w, input logic [31:0] a, input int l, input dat_t d, input bit mess);
    int g;
    plan(m, w, a, l, d, cyc, 99, g);
    drive(m, w, a, l, d, g, mess);
  endtask

  task automatic pair(input bit w0, input logic [31:0] a0, input int l0, input bit w1, input logic [31:0] a1, input int l1);
    dat_t d0, d1;
    int g0, g1, c;
    c = cyc; d0 = rnd_dat(); d1 = rnd_dat();
    if (!last) begin plan(1, w1, a1, l1, d1, c, 99, g1); plan(0, w0, a0, l0, d0, c, 99, g0); end
    else begin plan(0, w0, a0, l0, d0, c, 99, g0); plan(1, w1, a1, l1, d1, c, 99, g1); end
    fork
      drive(0, w0, a0, l0, d0, g0, 0);
      drive(1, w1, a1, l1, d1, g1, 0);
    join
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom % 8)
      0: return 32'hFFFFFFF0 + 32'(4 * ($urandom % 4));
      1: return 32'($urandom % 256);
      default: return {24'd0, 6'($urandom), 2'b00};
    endcase
  endfunction

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dat_t d;
    int g;
    for (int m = 0; m < 2; m++) begin addr_v[m] = 0; wd[m] = 0; len_v[m] = 0; hold[m] = 0; end
    sram[32'h4] = 32'h0A000008;
    ref_mem[32'h4] = 32'h0A000008;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    #1 rst = 1;
    idle_from = cyc;
    step();
    pair(0, 32'h100, 1, 0, 32'h104, 1);
    pair(0, 32'h108, 1, 0, 32'h10C, 1);
    single(0, 0, 32'h4, 0, rnd_dat(), 0);
    for (int k = 0; k < 16; k++) d[k] = 32'h11111111 * (k + 1);
    single(1, 1, 32'h10, 3, d, 0);
    single(0, 0, 32'h10, 3, rnd_dat(), 0);
    single(0, 0, 32'hFFFFFFFC, 1, rnd_dat(), 0);
    single(0, 0, 32'h22, 2, rnd_dat(), 0);
    single(0, 1, 32'h30, 3, rnd_dat(), 1);
    single(1, 0, 32'h30, 3, rnd_dat(), 0);
    d = rnd_dat();
    plan(0, 1, 32'h40, 7, d, cyc, 2, g);
    fork
      drive(0, 1, 32'h40, 7, d, g, 0);
      begin
        while (cyc < g + 2) step();
        #2 rst = 0;
        bq.delete(); rvq[0].delete(); rvq[1].delete();
        hold[0] = 0; hold[1] = 0;
        #1;
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("midrst_done", {m1_done, m0_done}, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        step(); step();
        rst = 1;
        idle_from = cyc;
        last = 1;
      end
    join
    pair(0, 32'h40, 3, 0, 32'h48, 1);
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom % 3) step();
      if ($urandom % 3 == 0) pair(1'($urandom), rnd_addr(), $urandom % 16, 1'($urandom), rnd_addr(), $urandom % 16);
      else single($urandom % 2, 1'($urandom), rnd_addr(), $urandom % 16, rnd_dat(), ($urandom % 4) == 0);
    end
    repeat (4) step();
    chk("beats_left", bq.size(), 0);
    chk("m0_reads_left", rvq[0].size(), 0);
    chk("m1_reads_left", rvq[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
